// File: rtl/fb_writer_pkg.sv
// Shared types and constants for the frame-buffer writer.
// Optional FILL engine is enabled by defining FB_WRITER_FILL_EN.
package fb_writer_pkg;

    localparam int ADR_W = 19;
    localparam int REG_W = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2
    } state_t;

    localparam logic [1:0] OFF_ADDR   = 2'd0;
    localparam logic [1:0] OFF_PIXEL  = 2'd1;
    localparam logic [1:0] OFF_FILL   = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_ERR  = 1;

endpackage

// File: rtl/fb_cursor.sv
// Frame-buffer address cursor: range-checked load and wrapping increment.
module fb_cursor
    import fb_writer_pkg::*;
#(
    parameter int DEPTH = 307200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [ADR_W-1:0] load_val,
    input  logic             inc,
    output logic [ADR_W-1:0] cursor,
    output logic             load_bad
);

    localparam logic [ADR_W-1:0] LAST = ADR_W'(DEPTH - 1);

    assign load_bad = load_val > LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cursor <= '0;
        end else if (load) begin
            cursor <= load_bad ? '0 : load_val;
        end else if (inc) begin
            cursor <= (cursor == LAST) ? '0 : cursor + 1'b1;
        end
    end

endmodule

// File: rtl/fb_writer.sv
// CPU-driven frame-buffer pixel writer with single-pixel and FILL modes.
// FILL mode is built only when FB_WRITER_FILL_EN is defined.
module fb_writer
    import fb_writer_pkg::*;
#(
    parameter int FB_DEPTH = 307200,
    parameter int PIX_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_sel,
    input  logic             cpu_we,
    input  logic [1:0]       cpu_off,
    input  logic [REG_W-1:0] cpu_wdata,
    output logic [REG_W-1:0] cpu_rdata,
    output logic             fb_we,
    output logic [ADR_W-1:0] fb_adr,
    output logic [PIX_W-1:0] fb_data
);

    state_t state;
    state_t state_nxt;

    logic [ADR_W-1:0] cursor;
    logic [ADR_W-1:0] remaining;
    logic [PIX_W-1:0] color;
    logic             err;
    logic             busy;
    logic             idle;
    logic             load_bad;

    logic wr;
    logic wr_addr;
    logic wr_pix;
    logic wr_fill;
    logic wr_stat;
    logic fill_start;
    logic fill_busy_err;
    logic err_set;
    logic err_clr;

    assign wr      = cpu_sel & cpu_we;
    assign wr_addr = wr & (cpu_off == OFF_ADDR);
    assign wr_pix  = wr & (cpu_off == OFF_PIXEL);
    assign wr_fill = wr & (cpu_off == OFF_FILL);
    assign wr_stat = wr & (cpu_off == OFF_STATUS);

    assign idle = (state == IDLE);

`ifdef FB_WRITER_FILL_EN
    assign busy          = (state == WRITE) | (state == FILL);
    assign fill_start    = wr_fill & idle & (|cpu_wdata[ADR_W-1:0]);
    assign fill_busy_err = wr_fill & busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
        end else if (fill_start) begin
            remaining <= cpu_wdata[ADR_W-1:0];
        end else if (state == FILL) begin
            remaining <= remaining - 1'b1;
        end
    end
`else
    // Without the fill engine, FILL writes vanish silently.
    assign busy          = (state == WRITE);
    assign fill_start    = 1'b0;
    assign fill_busy_err = 1'b0;
    assign remaining     = '0;
`endif

    fb_cursor #(
        .DEPTH(FB_DEPTH)
    ) u_cursor (
        .clk     (clk),
        .reset   (reset),
        .load    (wr_addr & idle),
        .load_val(cpu_wdata[ADR_W-1:0]),
        .inc     (busy),
        .cursor  (cursor),
        .load_bad(load_bad)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        unique case (state)
            IDLE: begin
                if (wr_pix) begin
                    state_nxt = WRITE;
                end else if (fill_start) begin
                    state_nxt = FILL;
                end
            end
            WRITE: state_nxt = IDLE;
`ifdef FB_WRITER_FILL_EN
            FILL: begin
                if (remaining > 1) begin
                    state_nxt = FILL;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color <= '0;
        end else if (wr_pix & idle) begin
            color <= cpu_wdata[PIX_W-1:0];
        end
    end

    assign err_set = (wr_addr & idle & load_bad)
                   | (busy & (wr_addr | wr_pix))
                   | fill_busy_err;
    assign err_clr = wr_stat & cpu_wdata[STAT_ERR];

    // A new error outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    // Address and data come straight from registers; fb_we tracks state,
    // so an asynchronous reset drops it at once.
    assign fb_we   = busy;
    assign fb_adr  = cursor;
    assign fb_data = color;

    always_comb begin
        cpu_rdata = '0;
        unique case (cpu_off)
            OFF_ADDR:  cpu_rdata = REG_W'(cursor);
            OFF_PIXEL: cpu_rdata = REG_W'(color);
            OFF_FILL:  cpu_rdata = REG_W'(remaining);
            default: begin
                cpu_rdata[STAT_ERR]  = err;
                cpu_rdata[STAT_BUSY] = busy;
            end
        endcase
    end

endmodule
